// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared types for the unified instruction/data memory arbiter.
// Arbiter state and owner enums, memory latency limits, counter load helper.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } owner_t;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;

    // Counter preload for a given read latency, clamped to the legal range.
    function automatic logic [3:0] lat_load(input int lat);
        int l;
        l = lat;
        if (l < MEM_LAT_MIN) l = MEM_LAT_MIN;
        if (l > MEM_LAT_MAX) l = MEM_LAT_MAX;
        return 4'(l - 1);
    endfunction

endpackage

// File: rtl/mem_lat_cnt.sv
// mem_lat_cnt: loadable 4-bit down-counter with zero flag (memory latency).
// Ports: clk, rst, load/load_val preset, dec step, zero flag.
module mem_lat_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency memory between fetch and data.
// Ports: if_* fetch side, d_* data side, mem_* memory macro, pipe_stall.
// Option: define ARB_FAIR_EN to bound data grants while a fetch waits.
module unified_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1,
    parameter int STREAK  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ready,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          pipe_stall
);

    localparam logic [3:0] LAT_LD = lat_load(MEM_LAT);

    arb_state_t state_q, state_d;
    owner_t     owner_q;
    logic       we_q;
    logic       kill_q;
    logic       grant_d, grant_if;
    logic       force_if;
    logic       fetch_ok;
    logic       cnt_zero;
    logic       capture;
    logic       unused_streak;

    assign unused_streak = (STREAK != 0);
    assign fetch_ok      = if_req & ~if_flush;

`ifdef ARB_FAIR_EN
    localparam logic [7:0] STREAK_MAX = 8'(STREAK);
    logic [7:0] streak_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= 8'd0;
        end else if (grant_if) begin
            streak_q <= 8'd0;
        end else if (grant_d && if_req && streak_q != STREAK_MAX) begin
            streak_q <= streak_q + 8'd1;
        end
    end

    assign force_if = fetch_ok & (streak_q >= STREAK_MAX);
`else
    assign force_if = 1'b0;
`endif

    always_comb begin
        grant_d  = 1'b0;
        grant_if = 1'b0;
        if (state_q == IDLE) begin
            if (force_if) begin
                grant_if = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end else if (fetch_ok) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_d || grant_if) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (cnt_zero) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The final WAIT cycle (count 0) is the one where mem_rdata is valid.
    assign capture = (state_q == WAIT) && cnt_zero;

    mem_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (state_q == ISSUE),
        .load_val (LAT_LD),
        .dec      (state_q == WAIT),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IF;
            we_q      <= 1'b0;
            kill_q    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            state_q <= state_d;
            if (grant_d) begin
                owner_q   <= OWN_D;
                we_q      <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_if) begin
                owner_q  <= OWN_IF;
                we_q     <= 1'b0;
                mem_addr <= if_addr;
            end
            if (state_q == IDLE) begin
                kill_q <= 1'b0;
            end else if (owner_q == OWN_IF && if_flush &&
                         (state_q == ISSUE || state_q == WAIT)) begin
                kill_q <= 1'b1;
            end
            if (capture) begin
                if (owner_q == OWN_IF) begin
                    if (!kill_q && !if_flush) if_rdata <= mem_rdata;
                end else if (!we_q) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        if_ready = 1'b0;
        d_ready  = 1'b0;
        unique case (1'b1)
            (state_q == ISSUE): begin
                mem_en = 1'b1;
                mem_we = we_q;
            end
            (state_q == RESP): begin
                if_ready = (owner_q == OWN_IF) & ~kill_q & ~if_flush;
                d_ready  = (owner_q == OWN_D);
            end
            default: ;
        endcase
    end

    assign pipe_stall = (if_req & ~if_ready) | (d_req & ~d_ready);

endmodule
